// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 width codes, FSM state encoding and default timeout for the load/store unit.
package lsu_pkg;
    localparam int TIMEOUT_CYCLES_DEF = 16;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane enables and store replication, plus load lane select with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata
);
    logic [31:0] w_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    always_comb begin
        o_be    = (i_funct3[1:0] == 2'b00) ? 4'b0001 << i_addr
                : (i_funct3[1:0] == 2'b01) ? 4'b0011 << {i_addr[1], 1'b0}
                : 4'b1111;
        o_wdata = (i_funct3[1:0] == 2'b00) ? {4{i_wdata[7:0]}}
                : (i_funct3[1:0] == 2'b01) ? {2{i_wdata[15:0]}}
                : i_wdata;
        w_shift = i_rdata >> {i_addr, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = w_shift[15:0];
        o_rdata = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte}
                : (i_funct3 == F3_BU) ? {24'd0, w_byte}
                : (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half}
                : (i_funct3 == F3_HU) ? {16'd0, w_half}
                : i_rdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer with a single outstanding memory request and timeout abort.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_misalign,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);
    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic        r_we, r_err, r_misalign;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic        w_illegal, w_misalign, w_fault, w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load;
    assign w_illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) || (req_funct3[2] && req_we);
    assign w_misalign = !w_illegal && (((req_funct3[1:0] == 2'b01) && req_addr[0])
                      || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)));
    assign w_fault    = w_illegal || w_misalign;
    assign w_timeout  = (r_cnt == LP_LAST);
    lsu_align u_align (
        .i_funct3 (r_funct3),
        .i_addr   (r_addr[1:0]),
        .i_wdata  (r_wdata),
        .i_rdata  (mem_rdata),
        .o_be     (w_be),
        .o_wdata  (w_wdata),
        .o_rdata  (w_load)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == S_IDLE) ? (req_valid ? (w_fault ? S_DONE : S_REQ) : S_IDLE)
               : (r_state == S_REQ)  ? ((mem_ready || w_timeout) ? S_DONE : S_REQ)
               : S_IDLE;
    end
    // Faults skip memory entirely; their flags are captured at acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_misalign <= 1'b0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_cnt      <= '0;
            r_we       <= req_we;
            r_funct3   <= req_funct3;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            r_rdata    <= '0;
            r_err      <= w_illegal;
            r_misalign <= w_misalign;
        end else if (r_state == S_REQ) begin
            r_cnt <= r_cnt + 8'd1;
            if (mem_ready) begin
                r_rdata <= r_we ? 32'd0 : w_load;
                r_err   <= 1'b0;
            end else if (w_timeout) begin
                r_err   <= 1'b1;
            end
        end
    end
    always_comb begin
        stall        = (r_state == S_IDLE && req_valid) || (r_state == S_REQ);
        mem_req      = (r_state == S_REQ);
        mem_we       = mem_req && r_we;
        mem_addr     = mem_req ? {r_addr[31:2], 2'b00} : 32'd0;
        mem_be       = mem_req ? w_be : 4'd0;
        mem_wdata    = mem_req ? w_wdata : 32'd0;
        rsp_valid    = (r_state == S_DONE);
        rsp_rdata    = rsp_valid ? r_rdata : 32'd0;
        rsp_misalign = rsp_valid && r_misalign;
        rsp_err      = rsp_valid && r_err;
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios for the load/store unit with hand-computed expectations.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        stall, rsp_valid, rsp_misalign, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;
    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign), .rsp_err(rsp_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
    endtask

    task automatic go_idle();
        req_valid = 1'b0;
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_ctrl got req=%b stall=%b vld=%b want 0 0 0", mem_req, stall, rsp_valid); end
        checks++; if (mem_be !== 4'd0 || mem_addr !== 32'd0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_data got be=%b addr=%h rd=%h want 0", mem_be, mem_addr, rsp_rdata); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_store_word();
        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        #1;
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL sw_accept got stall=%b req=%b want 1 0", stall, mem_req); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL sw_req got req=%b we=%b stall=%b want 1 1 1", mem_req, mem_we, stall); end
        checks++; if (mem_be !== 4'b1111 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_bus got be=%b addr=%h wd=%h want 1111 10 deadbeef", mem_be, mem_addr, mem_wdata); end
        mem_ready = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b1 || stall !== 1'b0 || mem_req !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL sw_rsp got vld=%b stall=%b req=%b err=%b rd=%h want 1 0 0 0 0", rsp_valid, stall, mem_req, rsp_err, rsp_rdata); end
        go_idle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_pulse got vld=%b want 0", rsp_valid); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3 [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad [4] = '{32'h13, 32'h13, 32'h22, 32'h22};
        logic [31:0] rd [4] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h80011234};
        logic [31:0] ex [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        logic [3:0]  be [4] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100};
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, f3[i], ad[i], 32'hFFFFFFFF);
            step();
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== be[i]) begin errors++; $display("FAIL load%0d_bus got req=%b we=%b be=%b want 1 0 %b", i, mem_req, mem_we, mem_be, be[i]); end
            mem_ready = 1'b1;
            mem_rdata = rd[i];
            step();
            checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== ex[i]) begin errors++; $display("FAIL load%0d_data got vld=%b rd=%h want 1 %h", i, rsp_valid, rsp_rdata, ex[i]); end
            go_idle();
        end
    endtask

    task automatic test_store_half();
        issue(1'b1, 3'b001, 32'h22, 32'h1234ABCD);
        step();
        checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hABCDABCD || mem_addr !== 32'h20) begin errors++; $display("FAIL sh_bus got be=%b wd=%h addr=%h want 1100 abcdabcd 20", mem_be, mem_wdata, mem_addr); end
        mem_ready = 1'b1;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL sh_rsp got vld=%b err=%b want 1 0", rsp_valid, rsp_err); end
        go_idle();
    endtask

    task automatic test_faults();
        issue(1'b0, 3'b010, 32'h06, 32'h0);
        mem_rdata = 32'h12345678;
        step();
        checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_misalign !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL lw_misalign got req=%b vld=%b mis=%b err=%b rd=%h want 0 1 1 0 0", mem_req, rsp_valid, rsp_misalign, rsp_err, rsp_rdata); end
        go_idle();
        issue(1'b0, 3'b011, 32'h04, 32'h0);
        step();
        checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_misalign !== 1'b0) begin errors++; $display("FAIL f3_011 got req=%b vld=%b err=%b mis=%b want 0 1 1 0", mem_req, rsp_valid, rsp_err, rsp_misalign); end
        go_idle();
        issue(1'b1, 3'b100, 32'h01, 32'h0);
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_misalign !== 1'b0) begin errors++; $display("FAIL sbu_illegal got vld=%b err=%b mis=%b want 1 1 0", rsp_valid, rsp_err, rsp_misalign); end
        go_idle();
        issue(1'b0, 3'b001, 32'h21, 32'h0);
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_misalign !== 1'b1 || rsp_err !== 1'b0) begin errors++; $display("FAIL lh_misalign got vld=%b mis=%b err=%b want 1 1 0", rsp_valid, rsp_misalign, rsp_err); end
        go_idle();
    endtask

    task automatic test_timeout(input logic ready_at_16);
        int n = 0;
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        mem_rdata = 32'h11223344;
        step();
        while (mem_req === 1'b1 && n < 40) begin
            n++;
            if (ready_at_16 && n == 16) mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
        checks++; if (n != 16) begin errors++; $display("FAIL timeout%0d_cycles got %0d want 16", ready_at_16, n); end
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== !ready_at_16) begin errors++; $display("FAIL timeout%0d_rsp got vld=%b err=%b want 1 %b", ready_at_16, rsp_valid, rsp_err, !ready_at_16); end
        checks++; if (rsp_rdata !== (ready_at_16 ? 32'h11223344 : 32'd0)) begin errors++; $display("FAIL timeout%0d_data got %h", ready_at_16, rsp_rdata); end
        go_idle();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        issue(1'b0, 3'b010, 32'h50, 32'h0);
        step();
        step();
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req3 got %b want 1", mem_req); end
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_be !== 4'd0) begin errors++; $display("FAIL rstmid_async got req=%b be=%b want 0 0000", mem_req, mem_be); end
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid === 1'b1) pulses++;
            step();
        end
        checks++; if (pulses != 0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_norsp got %0d pulses want 0", pulses); end
        rst = 1'b0;
        issue(1'b0, 3'b010, 32'h54, 32'h0);
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h54) begin errors++; $display("FAIL rstmid_first got req=%b addr=%h want 1 54", mem_req, mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || rsp_err !== 1'b0) begin errors++; $display("FAIL rstmid_rsp got vld=%b rd=%h err=%b want 1 cafef00d 0", rsp_valid, rsp_rdata, rsp_err); end
        go_idle();
    endtask

    task automatic test_back_to_back();
        issue(1'b1, 3'b000, 32'h01, 32'h0000005A);
        step();
        checks++; if (mem_be !== 4'b0010 || mem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b_sb got be=%b wd=%h want 0010 5a5a5a5a", mem_be, mem_wdata); end
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        issue(1'b0, 3'b100, 32'h02, 32'h0);
        checks++; if (rsp_valid !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_done got vld=%b stall=%b want 1 0", rsp_valid, stall); end
        step();
        checks++; if (mem_req !== 1'b0 || rsp_valid !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL b2b_idle got req=%b vld=%b stall=%b want 0 0 1", mem_req, rsp_valid, stall); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_be !== 4'b0100) begin errors++; $display("FAIL b2b_lbu_req got req=%b be=%b want 1 0100", mem_req, mem_be); end
        mem_ready = 1'b1;
        mem_rdata = 32'h00AB0000;
        step();
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h000000AB) begin errors++; $display("FAIL b2b_lbu_data got vld=%b rd=%h want 1 000000ab", rsp_valid, rsp_rdata); end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_store_half();
        test_faults();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
